// File: rtl/mcb_port_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mcb_port_model
// Purpose  : On-chip RAM responder for the MCB-style user port (cmd/wr/rd
//            FIFOs). It emulates the DDR2 controller side so that burst
//            logic can run without external memory.
// Ports    : rst/mem_clk      - async active-high reset, single clock
//            calib_done_o     - model ready (CALIB_DELAY cycles after reset)
//            cmd_*            - command FIFO push side and flags
//            wr_*             - write-data FIFO push side, flags, errors
//            rd_*             - read-data FIFO (FWFT) pop side, flags, errors
//            cmd/wr/rd_clk_i  - tied to mem_clk externally, not used inside
// Revision : 1.0 - initial release
// ============================================================================

// Synchronous FIFO with exact occupancy count and first-word-fall-through head.
module mcb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end
endmodule

module mcb_port_model #(
  parameter int MEM_DATA_BITS   = 64,
  parameter int RAM_ADDR_BITS   = 10,
  parameter int CMD_FIFO_DEPTH  = 4,
  parameter int DATA_FIFO_DEPTH = 64,
  parameter int CALIB_DELAY     = 16
) (
  input  logic                       rst,
  input  logic                       mem_clk,
  output logic                       calib_done_o,
  input  logic                       cmd_clk_i,
  input  logic                       wr_clk_i,
  input  logic                       rd_clk_i,
  input  logic                       cmd_en_i,
  input  logic [2:0]                 cmd_instr_i,
  input  logic [5:0]                 cmd_bl_i,
  input  logic [29:0]                cmd_byte_addr_i,
  output logic                       cmd_empty_o,
  output logic                       cmd_full_o,
  input  logic                       wr_en_i,
  input  logic [MEM_DATA_BITS/8-1:0] wr_mask_i,
  input  logic [MEM_DATA_BITS-1:0]   wr_data_i,
  output logic                       wr_full_o,
  output logic                       wr_empty_o,
  output logic [6:0]                 wr_count_o,
  output logic                       wr_underrun_o,
  output logic                       wr_error_o,
  input  logic                       rd_en_i,
  output logic [MEM_DATA_BITS-1:0]   rd_data_o,
  output logic                       rd_full_o,
  output logic                       rd_empty_o,
  output logic [6:0]                 rd_count_o,
  output logic                       rd_overflow_o,
  output logic                       rd_error_o
);
  localparam int BYTES  = MEM_DATA_BITS / 8;
  localparam int SHIFT  = $clog2(BYTES);
  localparam int CMD_W  = 9 + RAM_ADDR_BITS;
  localparam int CMD_CW = $clog2(CMD_FIFO_DEPTH + 1);
  localparam int CAL_W  = $clog2(CALIB_DELAY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WR_EXEC, S_RD_EXEC, S_NOP} state_t;

  state_t                     state_q, state_d;
  logic [RAM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [6:0]                 left_q, left_d;      // beats still to write / issue
  logic                       rd_vld_q;            // RAM read in flight, lands next edge
  logic [MEM_DATA_BITS-1:0]   rd_word_q;
  logic [CAL_W-1:0]           calib_cnt_q;
  logic                       calib_done_q;
  logic                       wr_error_q, rd_error_q, rd_overflow_q;
  logic [MEM_DATA_BITS-1:0]   ram_q [2**RAM_ADDR_BITS];

  logic                       cmd_pop, wr_pop, ram_we, rd_issue, underrun;
  logic [29:0]                cmd_word_addr;
  logic [CMD_W-1:0]           cmd_head;
  logic [CMD_CW-1:0]          cmd_count;
  logic [BYTES+MEM_DATA_BITS-1:0] wr_head;
  logic [MEM_DATA_BITS-1:0]   rd_head;
  logic [7:0]                 rd_pending;
  logic                       unused_sigs;

  assign cmd_word_addr = cmd_byte_addr_i >> SHIFT;
  assign unused_sigs   = ^{cmd_clk_i, wr_clk_i, rd_clk_i, cmd_count,
                           cmd_word_addr[29:RAM_ADDR_BITS]};

  mcb_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_FIFO_DEPTH), .CW(CMD_CW)) u_cmd_fifo (
    .rst(rst), .clk(mem_clk), .push_i(cmd_en_i), .pop_i(cmd_pop),
    .din_i({cmd_instr_i, cmd_bl_i, cmd_word_addr[RAM_ADDR_BITS-1:0]}),
    .dout_o(cmd_head), .full_o(cmd_full_o), .empty_o(cmd_empty_o), .count_o(cmd_count)
  );

  mcb_fifo #(.WIDTH(BYTES + MEM_DATA_BITS), .DEPTH(DATA_FIFO_DEPTH), .CW(7)) u_wr_fifo (
    .rst(rst), .clk(mem_clk), .push_i(wr_en_i), .pop_i(wr_pop),
    .din_i({wr_mask_i, wr_data_i}),
    .dout_o(wr_head), .full_o(wr_full_o), .empty_o(wr_empty_o), .count_o(wr_count_o)
  );

  mcb_fifo #(.WIDTH(MEM_DATA_BITS), .DEPTH(DATA_FIFO_DEPTH), .CW(7)) u_rd_fifo (
    .rst(rst), .clk(mem_clk), .push_i(rd_vld_q), .pop_i(rd_en_i),
    .din_i(rd_word_q),
    .dout_o(rd_head), .full_o(rd_full_o), .empty_o(rd_empty_o), .count_o(rd_count_o)
  );

  assign calib_done_o  = calib_done_q;
  assign wr_underrun_o = underrun;
  assign wr_error_o    = wr_error_q;
  assign rd_error_o    = rd_error_q;
  assign rd_overflow_o = rd_overflow_q;
  assign rd_data_o     = rd_empty_o ? '0 : rd_head;

  // Space check counts the beat already in flight so the read FIFO never overflows.
  assign rd_pending = {1'b0, rd_count_o} + {7'b0, rd_vld_q};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    cmd_pop  = 1'b0;
    wr_pop   = 1'b0;
    ram_we   = 1'b0;
    rd_issue = 1'b0;
    underrun = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (calib_done_q && !cmd_empty_o) begin
          cmd_pop = 1'b1;
          addr_d  = cmd_head[RAM_ADDR_BITS-1:0];
          left_d  = {1'b0, cmd_head[RAM_ADDR_BITS +: 6]} + 7'd1;
          if (cmd_head[CMD_W-1])       state_d = S_NOP;
          else if (cmd_head[CMD_W-3])  state_d = S_RD_EXEC;
          else                         state_d = S_WR_EXEC;
        end
      end
      S_NOP: state_d = S_IDLE;
      S_WR_EXEC: begin
        if (!wr_empty_o) begin
          wr_pop = 1'b1;
          ram_we = 1'b1;
          addr_d = addr_q + RAM_ADDR_BITS'(1);
          left_d = left_q - 7'd1;
          if (left_q == 7'd1) state_d = S_IDLE;
        end else begin
          underrun = 1'b1;
        end
      end
      S_RD_EXEC: begin
        // left_q reaches 0 once the last read is issued; that beat lands on
        // the same edge that returns the FSM to IDLE.
        if (left_q == 7'd0) begin
          state_d = S_IDLE;
        end else if (rd_pending < 8'(DATA_FIFO_DEPTH)) begin
          rd_issue = 1'b1;
          addr_d   = addr_q + RAM_ADDR_BITS'(1);
          left_d   = left_q - 7'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM contents deliberately have no reset so data survives rst.
  always_ff @(posedge mem_clk) begin
    if (ram_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!wr_head[MEM_DATA_BITS + b]) ram_q[addr_q][b*8 +: 8] <= wr_head[b*8 +: 8];
      end
    end
    if (rd_issue) rd_word_q <= ram_q[addr_q];
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      left_q        <= '0;
      rd_vld_q      <= 1'b0;
      calib_cnt_q   <= '0;
      calib_done_q  <= 1'b0;
      wr_error_q    <= 1'b0;
      rd_error_q    <= 1'b0;
      rd_overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      rd_vld_q <= rd_issue;
      if (!calib_done_q) begin
        if (calib_cnt_q == CAL_W'(CALIB_DELAY - 1)) calib_done_q <= 1'b1;
        else                                         calib_cnt_q  <= calib_cnt_q + CAL_W'(1);
      end
      if (wr_en_i && wr_full_o)   wr_error_q    <= 1'b1;
      if (rd_en_i && rd_empty_o)  rd_error_q    <= 1'b1;
      if (rd_vld_q && rd_full_o)  rd_overflow_q <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mcb_port_model.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mcb_port_model
// Purpose  : Self-checking bench for mcb_port_model. A word-array memory model
//            predicts read data from the write history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcb_port_model;
  logic        rst, mem_clk;
  logic        calib_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty, cmd_full;
  logic        wr_en;
  logic [7:0]  wr_mask;
  logic [63:0] wr_data;
  logic        wr_full, wr_empty, wr_underrun, wr_error;
  logic [6:0]  wr_count;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        rd_full, rd_empty, rd_overflow, rd_error;
  logic [6:0]  rd_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mdl [1024];
  logic [63:0] beat_d [128];
  logic [7:0]  beat_m [128];
  logic [63:0] got [128];

  mcb_port_model dut (
    .rst(rst), .mem_clk(mem_clk), .calib_done_o(calib_done),
    .cmd_clk_i(mem_clk), .wr_clk_i(mem_clk), .rd_clk_i(mem_clk),
    .cmd_en_i(cmd_en), .cmd_instr_i(cmd_instr), .cmd_bl_i(cmd_bl),
    .cmd_byte_addr_i(cmd_byte_addr), .cmd_empty_o(cmd_empty), .cmd_full_o(cmd_full),
    .wr_en_i(wr_en), .wr_mask_i(wr_mask), .wr_data_i(wr_data),
    .wr_full_o(wr_full), .wr_empty_o(wr_empty), .wr_count_o(wr_count),
    .wr_underrun_o(wr_underrun), .wr_error_o(wr_error),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_full_o(rd_full), .rd_empty_o(rd_empty),
    .rd_count_o(rd_count), .rd_overflow_o(rd_overflow), .rd_error_o(rd_error)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge mem_clk);
  endtask

  // Byte address for a word, with random junk above and below the word field.
  function automatic logic [29:0] baddr(input int word);
    return {17'($urandom), 10'(word), 3'($urandom)};
  endfunction

  task automatic send_cmd(input logic [2:0] instr, input int beats, input int word);
    cmd_en = 1'b1; cmd_instr = instr; cmd_bl = 6'(beats - 1); cmd_byte_addr = baddr(word);
    tick();
    cmd_en = 1'b0;
  endtask

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = beat_d[i]; wr_mask = beat_m[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic model_write(input int word, input int n);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        if (!beat_m[i][b]) mdl[(word + i) % 1024][b*8 +: 8] = beat_d[i][b*8 +: 8];
  endtask

  task automatic drain_wr(output bit ok);
    int g = 0;
    while (!(wr_empty && cmd_empty) && g < 500) begin tick(); g++; end
    ok = (g < 500);
    tick(); tick();
  endtask

  task automatic read_burst(input int n, output bit ok);
    int cnt = 0;
    int g = 0;
    while (cnt < n && g < 3000) begin
      if (!rd_empty) begin got[cnt] = rd_data; cnt++; rd_en = 1'b1; end
      else rd_en = 1'b0;
      tick(); g++;
    end
    rd_en = 1'b0;
    ok = (cnt == n);
  endtask

  task automatic do_write(input int word, input int n);
    bit ok;
    push_beats(n);
    send_cmd(3'b000, n, word);
    model_write(word, n);
    drain_wr(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wr_drain: write at word %0d never drained", word); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_en = 0; cmd_instr = 0; cmd_bl = 0; cmd_byte_addr = 0;
    wr_en = 0; wr_mask = 0; wr_data = 0; rd_en = 0;
    tick(); tick();
    n_cmp++;
    if ({calib_done, cmd_empty, cmd_full, wr_empty, wr_full, rd_empty, rd_full} !== 7'b0101010) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0101010",
        {calib_done, cmd_empty, cmd_full, wr_empty, wr_full, rd_empty, rd_full});
    end
    n_cmp++;
    if ({wr_count, rd_count, wr_error, rd_error, rd_overflow, wr_underrun, rd_data} !== '0) begin
      n_bad++; $display("FAIL reset_zero: wr_count=%0d rd_count=%0d errs=%b%b%b%b rd_data=%h want all 0",
        wr_count, rd_count, wr_error, rd_error, rd_overflow, wr_underrun, rd_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_cmp++;
    if (calib_done !== 1'b0) begin n_bad++; $display("FAIL calib_early: got %b after 15 cycles want 0", calib_done); end
    tick();
    n_cmp++;
    if (calib_done !== 1'b1) begin n_bad++; $display("FAIL calib_on: got %b after 16 cycles want 1", calib_done); end
  endtask

  task automatic test_basic_latency();
    bit ok;
    for (int i = 0; i < 8; i++) begin beat_d[i] = 64'(i + 1); beat_m[i] = 8'h00; end
    do_write(8, 8);                      // byte address 0x40 -> word 8
    cmd_en = 1'b1; cmd_instr = 3'b001; cmd_bl = 6'd7; cmd_byte_addr = 30'h40;
    tick();
    cmd_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (rd_empty !== 1'b1) begin n_bad++; $display("FAIL latency_early: rd_empty=%b at T+%0d want 1", rd_empty, k); end
      tick();
    end
    n_cmp++;
    if (rd_empty !== 1'b0 || rd_data !== 64'h1) begin
      n_bad++; $display("FAIL latency_first: rd_empty=%b rd_data=%h after T+3 want 0 / 1", rd_empty, rd_data);
    end
    read_burst(8, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_rd: burst incomplete want 8 beats"); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== 64'(i + 1)) begin n_bad++; $display("FAIL basic_beat%0d: got %h want %h", i, got[i], 64'(i + 1)); end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 64; i++) begin beat_d[i] = {$urandom, $urandom}; beat_m[i] = 8'h00; end
      do_write(blk * 64, 64);
    end
    for (int op = 0; op < 24; op++) begin
      int kind = $urandom_range(0, 3);
      int word = $urandom_range(0, 1023);
      int n    = $urandom_range(1, 64);
      if (kind <= 1) begin
        for (int i = 0; i < n; i++) begin beat_d[i] = {$urandom, $urandom}; beat_m[i] = 8'($urandom); end
        do_write(word, n);
      end else if (kind == 2) begin
        send_cmd({1'b0, 1'($urandom), 1'b1}, n, word);
        read_burst(n, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rand_rd: burst of %0d at %0d incomplete", n, word); end
        for (int i = 0; i < n; i++) begin
          n_cmp++;
          if (got[i] !== mdl[(word + i) % 1024]) begin
            n_bad++; $display("FAIL rand_beat: word %0d got %h want %h", (word + i) % 1024, got[i], mdl[(word + i) % 1024]);
          end
        end
      end else begin
        send_cmd({1'b1, 2'($urandom)}, n, word);
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (rd_empty !== 1'b1 || cmd_empty !== 1'b1) begin
          n_bad++; $display("FAIL nop: rd_empty=%b cmd_empty=%b want 1/1", rd_empty, cmd_empty);
        end
      end
    end
  endtask

  task automatic test_wr_overflow();
    bit ok;
    n_cmp++;
    if (wr_error !== 1'b0) begin n_bad++; $display("FAIL wr_error_pre: got %b want 0", wr_error); end
    for (int i = 0; i < 74; i++) begin beat_d[i] = {$urandom, $urandom}; beat_m[i] = 8'h00; end
    push_beats(74);
    n_cmp++;
    if (wr_count !== 7'd64 || wr_full !== 1'b1 || wr_error !== 1'b1) begin
      n_bad++; $display("FAIL wr_overflow: count=%0d full=%b err=%b want 64/1/1", wr_count, wr_full, wr_error);
    end
    send_cmd(3'b000, 64, 700);
    model_write(700, 64);
    drain_wr(ok);
    send_cmd(3'b001, 64, 700);
    read_burst(64, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ovf_rd: burst incomplete"); end
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (got[i] !== beat_d[i]) begin n_bad++; $display("FAIL ovf_beat%0d: got %h want %h", i, got[i], beat_d[i]); end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int uc = 0;
    for (int i = 0; i < 4; i++) begin beat_d[i] = {$urandom, $urandom}; beat_m[i] = 8'h00; end
    send_cmd(3'b000, 4, 40);
    for (int k = 0; k < 16; k++) begin
      if (wr_underrun === 1'b1) uc++;
      if (k >= 5 && k < 9) begin wr_en = 1'b1; wr_data = beat_d[k-5]; wr_mask = 8'h00; end
      else wr_en = 1'b0;
      tick();
    end
    model_write(40, 4);
    n_cmp++;
    if (uc != 5) begin n_bad++; $display("FAIL underrun_cycles: got %0d want 5", uc); end
    send_cmd(3'b001, 4, 40);
    read_burst(4, ok);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== beat_d[i]) begin n_bad++; $display("FAIL underrun_beat%0d: got %h want %h", i, got[i], beat_d[i]); end
    end
  endtask

  task automatic test_mask_wrap();
    bit ok;
    beat_d[0] = 64'hAAAA_AAAA_AAAA_AAAA; beat_m[0] = 8'h00;
    do_write(300, 1);
    beat_d[0] = 64'h0; beat_m[0] = 8'h0F;
    do_write(300, 1);
    send_cmd(3'b001, 1, 300);
    read_burst(1, ok);
    n_cmp++;
    if (got[0] !== 64'h0000_0000_AAAA_AAAA) begin
      n_bad++; $display("FAIL mask: got %h want 00000000aaaaaaaa", got[0]);
    end
    for (int i = 0; i < 4; i++) begin beat_d[i] = {$urandom, $urandom}; beat_m[i] = 8'h00; end
    do_write(1022, 4);
    send_cmd(3'b001, 2, 0);
    read_burst(2, ok);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (got[i] !== beat_d[i + 2]) begin n_bad++; $display("FAIL wrap_low%0d: got %h want %h", i, got[i], beat_d[i + 2]); end
    end
    send_cmd(3'b001, 4, 1022);
    read_burst(4, ok);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== beat_d[i]) begin n_bad++; $display("FAIL wrap_rd%0d: got %h want %h", i, got[i], beat_d[i]); end
    end
  endtask

  task automatic test_rd_full();
    bit ok;
    int g = 0;
    send_cmd(3'b001, 64, 0);
    while (!rd_full && g < 200) begin tick(); g++; end
    n_cmp++;
    if (rd_full !== 1'b1 || rd_count !== 7'd64 || rd_overflow !== 1'b0) begin
      n_bad++; $display("FAIL rd_full: full=%b count=%0d ovf=%b want 1/64/0", rd_full, rd_count, rd_overflow);
    end
    send_cmd(3'b001, 4, 100);
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (rd_count !== 7'd64 || rd_overflow !== 1'b0) begin
      n_bad++; $display("FAIL rd_stall: count=%0d ovf=%b want 64/0", rd_count, rd_overflow);
    end
    read_burst(68, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rd_full_drain: burst incomplete"); end
    for (int i = 0; i < 68; i++) begin
      int w = (i < 64) ? i : 100 + i - 64;
      n_cmp++;
      if (got[i] !== mdl[w]) begin n_bad++; $display("FAIL rd_full_beat%0d: got %h want %h", i, got[i], mdl[w]); end
    end
    n_cmp++;
    if (rd_error !== 1'b0) begin n_bad++; $display("FAIL rd_error_pre: got %b want 0", rd_error); end
    rd_en = 1'b1; tick(); rd_en = 1'b0; tick();
    n_cmp++;
    if (rd_error !== 1'b1 || rd_overflow !== 1'b0 || rd_count !== 7'd0) begin
      n_bad++; $display("FAIL rd_error: err=%b ovf=%b count=%0d want 1/0/0", rd_error, rd_overflow, rd_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_cmd(3'b001, 64, 0);
    for (int i = 0; i < 10; i++) tick();
    send_cmd(3'b001, 8, 200);
    for (int i = 0; i < 5; i++) begin beat_d[i] = {$urandom, $urandom}; beat_m[i] = 8'h00; end
    push_beats(5);
    n_cmp++;
    if (cmd_empty !== 1'b0 || rd_empty !== 1'b0 || wr_count !== 7'd5) begin
      n_bad++; $display("FAIL pre_rst: cmd_empty=%b rd_empty=%b wr_count=%0d want 0/0/5", cmd_empty, rd_empty, wr_count);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({calib_done, cmd_empty, wr_empty, rd_empty, wr_error, rd_error} !== 6'b011100 ||
        wr_count !== 7'd0 || rd_count !== 7'd0 || rd_data !== 64'h0) begin
      n_bad++; $display("FAIL mid_rst: flags=%b wr_count=%0d rd_count=%0d rd_data=%h want 011100/0/0/0",
        {calib_done, cmd_empty, wr_empty, rd_empty, wr_error, rd_error}, wr_count, rd_count, rd_data);
    end
    tick();
    rst = 1'b0;
    send_cmd(3'b001, 4, 500);
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (calib_done !== 1'b0 || rd_empty !== 1'b1) begin
      n_bad++; $display("FAIL precal_hold: calib=%b rd_empty=%b want 0/1", calib_done, rd_empty);
    end
    read_burst(4, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL post_rst_rd: burst incomplete"); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== mdl[500 + i]) begin n_bad++; $display("FAIL ram_kept%0d: got %h want %h", i, got[i], mdl[500 + i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_random();
    test_wr_overflow();
    test_underrun();
    test_mask_wrap();
    test_rd_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
